multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/rv32_cu_pkg.sv | 42 ++++
 rtl/multicycle_control_unit_if.sv | 30 +++
 rtl/cu_alu_decoder.sv | 24 ++
 rtl/multicycle_control_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/rv32_cu_pkg.sv
// Shared encodings for the multicycle RV32 control unit: states, opcodes,
// ALU codes and datapath select values.
package rv32_cu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StFetch  = 3'd0;
  localparam state_t StDecode = 3'd1;
  localparam state_t StExe    = 3'd2;
  localparam state_t StMem    = 3'd3;
  localparam state_t StWb     = 3'd4;
  localparam state_t StErr    = 3'd5;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpL     = 7'b0000011;
  localparam logic [6:0] OpS     = 7'b0100011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSra = 4'b1101;

  localparam logic [2:0] RfwdAlu   = 3'd0;
  localparam logic [2:0] RfwdLoad  = 3'd1;
  localparam logic [2:0] RfwdImm   = 3'd2;
  localparam logic [2:0] RfwdPcImm = 3'd3;
  localparam logic [2:0] RfwdPc4   = 3'd4;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcImm    = 2'd1;
  localparam logic [1:0] PcRs1Imm = 2'd2;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OpR) || (op == OpI) || (op == OpL) || (op == OpS) || (op == OpB) ||
           (op == OpLui) || (op == OpAuipc) || (op == OpJal) || (op == OpJalr);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/bus signal bundle; master is the control unit.
interface multicycle_control_unit_if #(
  parameter int unsigned ALU_CTRL_W = 4
);
  logic [31:0]           instrCode;
  logic                  btaken;
  logic                  busReady;
  logic                  irWe;
  logic                  pcEn;
  logic [1:0]            pcSrcSel;
  logic                  regFileWe;
  logic [ALU_CTRL_W-1:0] aluControl;
  logic                  aluSrcMuxSel;
  logic [2:0]            RFWDSrcMuxSel;
  logic                  busReq;
  logic                  busWe;
  logic                  busErr;

  modport master (
    input  instrCode, btaken, busReady,
    output irWe, pcEn, pcSrcSel, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
           busReq, busWe, busErr
  );

  modport slave (
    output instrCode, btaken, busReady,
    input  irWe, pcEn, pcSrcSel, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
           busReq, busWe, busErr
  );
endinterface

// File: rtl/cu_alu_decoder.sv
// Combinational ALU operation decode; yields ADD outside the execute/memory states.
module cu_alu_decoder
  import rv32_cu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       bit30_i,
  input  logic       decode_en_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = AluAdd;
    if (decode_en_i) begin
      case (opcode_i)
        OpR, OpB: alu_ctrl_o = {bit30_i, funct3_i};
        // Only the shift-right-arithmetic immediate carries a meaningful bit 30.
        OpI:      alu_ctrl_o = (funct3_i == 3'b101 && bit30_i) ? AluSra : {1'b0, funct3_i};
        default:  alu_ctrl_o = AluAdd;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXE/MEM/WB with a sticky error trap
// for illegal opcodes and data-bus timeouts.
module multicycle_control_unit
  import rv32_cu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter int unsigned ALU_CTRL_W  = 4
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_unit_if.master cu
);

  localparam int unsigned CntW = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BUS_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      opcode;
  logic            is_st, is_ld;
  logic [3:0]      alu_ctrl;

  assign opcode = cu.instrCode[6:0];
  assign is_st  = (opcode == OpS);
  assign is_ld  = (opcode == OpL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExe;
      StExe: begin
        if (!is_legal(opcode)) begin
          state_d = StErr;
        end else if (is_st || is_ld) begin
          state_d = StMem;
          cnt_d   = '0;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        // A ready in the last permitted cycle still completes the access.
        if (cu.busReady) begin
          state_d = is_st ? StFetch : StWb;
        end else if (BUS_TIMEOUT != 0 && cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb:    state_d = StFetch;
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cu.irWe          = 1'b0;
    cu.pcEn          = 1'b0;
    cu.pcSrcSel      = PcPlus4;
    cu.regFileWe     = 1'b0;
    cu.aluSrcMuxSel  = 1'b0;
    cu.RFWDSrcMuxSel = RfwdAlu;
    cu.busReq        = 1'b0;
    cu.busWe         = 1'b0;
    cu.busErr        = 1'b0;
    case (state_q)
      StFetch: cu.irWe = 1'b1;
      StExe: begin
        case (opcode)
          OpR: begin
            cu.regFileWe = 1'b1;
            cu.pcEn      = 1'b1;
          end
          OpI: begin
            cu.regFileWe    = 1'b1;
            cu.pcEn         = 1'b1;
            cu.aluSrcMuxSel = 1'b1;
          end
          OpLui: begin
            cu.regFileWe     = 1'b1;
            cu.pcEn          = 1'b1;
            cu.aluSrcMuxSel  = 1'b1;
            cu.RFWDSrcMuxSel = RfwdImm;
          end
          OpAuipc: begin
            cu.regFileWe     = 1'b1;
            cu.pcEn          = 1'b1;
            cu.aluSrcMuxSel  = 1'b1;
            cu.RFWDSrcMuxSel = RfwdPcImm;
          end
          OpB: begin
            cu.pcEn     = 1'b1;
            cu.pcSrcSel = cu.btaken ? PcImm : PcPlus4;
          end
          OpJal: begin
            cu.regFileWe     = 1'b1;
            cu.pcEn          = 1'b1;
            cu.pcSrcSel      = PcImm;
            cu.RFWDSrcMuxSel = RfwdPc4;
          end
          OpJalr: begin
            cu.regFileWe     = 1'b1;
            cu.pcEn          = 1'b1;
            cu.pcSrcSel      = PcRs1Imm;
            cu.aluSrcMuxSel  = 1'b1;
            cu.RFWDSrcMuxSel = RfwdPc4;
          end
          OpL, OpS: cu.aluSrcMuxSel = 1'b1;
          default: ;
        endcase
      end
      StMem: begin
        cu.busReq       = 1'b1;
        cu.busWe        = is_st;
        cu.aluSrcMuxSel = 1'b1;
        cu.pcEn         = is_st && cu.busReady;
      end
      StWb: begin
        cu.regFileWe     = 1'b1;
        cu.pcEn          = 1'b1;
        cu.RFWDSrcMuxSel = RfwdLoad;
      end
      StErr:   cu.busErr = 1'b1;
      default: ;
    endcase
  end

  cu_alu_decoder u_alu_decoder (
    .opcode_i    (opcode),
    .funct3_i    (cu.instrCode[14:12]),
    .bit30_i     (cu.instrCode[30]),
    .decode_en_i ((state_q == StExe) || (state_q == StMem)),
    .alu_ctrl_o  (alu_ctrl)
  );

  assign cu.aluControl = ALU_CTRL_W'(alu_ctrl);

endmodule
